// File: rtl/trimux_if.sv
// Slot-gather request bus: item descriptors in, per-destination-slot source index out.
interface trimux_if #(
  parameter int BSW = 5
);
  localparam int BS = 1 << BSW;
  localparam int WW = 8 - BSW + 1;

  logic [BSW:0]                inum;
  logic [BS-1:0][WW-1:0]       ilen;
  logic [BS-1:0][BSW-1:0]      ipos;
  logic [BS-1:0][BSW-1:0]      psum;
  logic [BS-1:0][BSW:0]        index;

  modport master (output inum, ilen, ipos, psum, input index);
  modport slave  (input inum, ilen, ipos, psum, output index);
endinterface

// File: rtl/trimux.sv
// Maps each destination slot to the source slot of the lowest active item covering it.
// Latency 1 cycle, one set per cycle, no backpressure; index reads "unused" (BS) during reset.
module trimux #(
  parameter int VLEN = 256,
  parameter int BSW  = 5
) (
  input logic     clk,
  input logic     rst,
  trimux_if.slave bus
);
  localparam int BS   = 1 << BSW;
  localparam int BLEN = VLEN / BS;
  localparam logic [BSW:0] UNUSED = (BSW+1)'(BS);

  if (BLEN * BS != VLEN) begin : g_bad_vlen
    $error("VLEN must be a multiple of the slot count");
  end

  logic [BS-1:0][BSW:0] s_w;
  logic [BS-1:0][BSW:0] e_w;
  logic [BS-1:0]        own_ok;
  logic [BS-1:0][BSW:0] index_nxt;
  logic [BS-1:0][BSW:0] index_q;

  always_comb begin
    s_w    = '0;
    e_w    = '0;
    own_ok = '0;
    for (int i = 0; i < BS; i++) begin
      own_ok[i] = ((BSW+1)'(i) < bus.inum) && (bus.ilen[i] != '0);
      e_w[i]    = {1'b0, bus.psum[i]};
      // A zero prefix sum on a non-empty item means the BSW-bit sum wrapped at a full vector.
      if (bus.psum[i] == '0 && own_ok[i]) e_w[i] = UNUSED;
      s_w[i] = e_w[i] - (BSW+1)'(bus.ilen[i]);
    end
  end

  always_comb begin
    logic [BSW:0] jj;
    logic [BSW:0] off;
    index_nxt = '0;
    jj        = '0;
    off       = '0;
    for (int j = 0; j < BS; j++) begin
      jj           = (BSW+1)'(j);
      index_nxt[j] = UNUSED;
      // Scan from the highest item down so the lowest covering item has the last word.
      for (int i = BS - 1; i >= 0; i--) begin
        if (own_ok[i] && (s_w[i] <= jj) && (jj < e_w[i])) begin
          off          = jj - s_w[i];
          index_nxt[j] = {1'b0, bus.ipos[i] + off[BSW-1:0]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < BS; j++) index_q[j] <= UNUSED;
    end else begin
      index_q <= index_nxt;
    end
  end

  assign bus.index = index_q;
endmodule

// File: tb/tb_trimux.sv
// Directed bench for trimux: async reset, gather patterns, wraps, priority and pipelining.
module tb_trimux;
  localparam int BSW = 5;
  localparam int BS  = 32;

  logic clk = 1'b0;
  logic rst;
  trimux_if #(.BSW(BSW)) bus ();
  trimux #(.VLEN(256), .BSW(BSW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  logic [5:0] exp_idx [BS];

  task automatic clear_in();
    bus.inum = '0;
    bus.ilen = '0;
    bus.ipos = '0;
    bus.psum = '0;
  endtask

  task automatic set_item(input int i, input int len, input int ps, input int pos);
    bus.ilen[i] = 4'(len);
    bus.psum[i] = 5'(ps);
    bus.ipos[i] = 5'(pos);
  endtask

  task automatic exp_clear();
    for (int j = 0; j < BS; j++) exp_idx[j] = 6'd32;
  endtask

  task automatic exp_run(input int d0, input int n, input int s0);
    for (int k = 0; k < n; k++) exp_idx[d0+k] = 6'((s0 + k) % 32);
  endtask

  task automatic check_all(input string tag);
    for (int j = 0; j < BS; j++) begin
      total++;
      assert (bus.index[j] === exp_idx[j]) passed++;
      else $error("FAIL %s slot %0d: got %0d, expected %0d", tag, j, bus.index[j], exp_idx[j]);
    end
  endtask

  task automatic load_basic();
    clear_in(); bus.inum = 6'd3;
    set_item(0, 4, 4, 0); set_item(1, 6, 10, 5); set_item(2, 3, 13, 11);
  endtask
  task automatic exp_basic();
    exp_clear(); exp_run(0, 4, 0); exp_run(4, 6, 5); exp_run(10, 3, 11);
  endtask

  task automatic load_zero();
    clear_in(); bus.inum = 6'd3;
    set_item(0, 2, 2, 4); set_item(1, 0, 2, 9); set_item(2, 3, 5, 20);
  endtask
  task automatic exp_zero();
    exp_clear(); exp_run(0, 2, 4); exp_run(2, 3, 20);
  endtask

  task automatic load_full();
    clear_in(); bus.inum = 6'd3;
    set_item(0, 15, 15, 0); set_item(1, 15, 30, 0); set_item(2, 2, 0, 0);
  endtask
  task automatic exp_full();
    exp_clear(); exp_run(0, 15, 0); exp_run(15, 15, 0); exp_run(30, 2, 0);
  endtask

  task automatic load_wrap();
    clear_in(); bus.inum = 6'd1;
    set_item(0, 4, 4, 30);
  endtask
  task automatic exp_wrap();
    exp_clear(); exp_run(0, 4, 30);
  endtask

  initial begin
    clear_in();
    rst = 1'b0;
    #1 rst = 1'b1;
    load_basic();
    #1 exp_clear(); check_all("reset_async");
    @(posedge clk); #1 check_all("reset_hold_edge");

    // First edge after release loads the inputs present at that edge.
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1 exp_basic(); check_all("basic");

    load_zero();
    @(posedge clk); #1 exp_zero(); check_all("zero_len");

    load_full();
    @(posedge clk); #1 exp_full(); check_all("full_vec");
    bus.inum = '0;
    @(posedge clk); #1 exp_clear(); check_all("inum_zero");

    load_wrap();
    @(posedge clk); #1 exp_wrap(); check_all("src_wrap");

    // Overlapping items: lower item keeps slots 2..3, item 1 only gets 4..5.
    clear_in(); bus.inum = 6'd2;
    set_item(0, 4, 4, 0); set_item(1, 4, 6, 10);
    set_item(2, 3, 9, 7);
    @(posedge clk); #1
    exp_clear(); exp_run(0, 4, 0); exp_run(4, 2, 12); check_all("priority_inactive");

    // Back-to-back sets: each result one edge after its inputs.
    load_basic();
    @(posedge clk); #1 exp_basic(); check_all("pipe_a");
    load_zero();
    @(posedge clk); #1 exp_zero(); check_all("pipe_b");
    load_full();
    #2 rst = 1'b1;
    #1 exp_clear(); check_all("reset_mid");
    @(negedge clk) rst = 1'b0;
    load_wrap();
    @(posedge clk); #1 exp_wrap(); check_all("post_reset_fresh");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/trimux.md
TRIMUX -- requirements
Module: trimux

Interface
REQ-001 Parameter VLEN, default 256, vector width in bits.
REQ-002 Parameter BSW, default 5, log2 of the slot count; BS = 2^BSW slots (32), BLEN = VLEN/BS bits per slot (8), WW = 8-BSW+1 length width (4).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 inum  input  BSW+1  number of active items (0..BS).
REQ-006 ilen  input  BS x WW  ilen[i] is the length in slots of item i (0..2^WW-1).
REQ-007 ipos  input  BS x BSW  ipos[i] is the source start slot of item i.
REQ-008 psum  input  BS x BSW  psum[i] is the inclusive prefix sum ilen[0]+..+ilen[i] (destination end slot, exclusive).
REQ-009 index  output  BS x (BSW+1)  index[j] is the source slot feeding destination slot j; value BS (MSB set, low bits 0) means slot unused.

Function
REQ-010 Item i is active iff i < inum; inactive items' ilen/ipos/psum are ignored.
REQ-011 Effective end E[i] = psum[i], except E[i] = BS when psum[i] == 0, i is active and ilen[i] != 0 (full-vector wrap of the BSW-bit sum).
REQ-012 Effective start S[i] = E[i] - ilen[i], computed at BSW+1 bits.
REQ-013 Destination slot j is owned by the smallest active i with S[i] <= j < E[i]; items with ilen[i] == 0 never own a slot.
REQ-014 For an owned slot, index[j] = {1'b0, (ipos[i] + (j - S[i])) mod BS}; the source slot wraps modulo BS.
REQ-015 A slot with no owner yields index[j] = BS.
REQ-016 inum == 0 makes every slot unused.
REQ-017 The ownership search is one comparator pair per (slot, item) pair with a priority select per slot, purely combinational from the inputs.
REQ-018 index is registered: inputs sampled at rising edge N appear on index after edge N; latency 1 cycle, throughput 1 set per cycle, no handshake.
REQ-019 Inputs with psum inconsistent with ilen still produce a deterministic result per REQ-011..REQ-015; no error flag.

Reset
REQ-020 While rst is high, every index[j] is BS (32) immediately, independent of clk.
REQ-021 The first rising edge after rst deasserts loads the result of the inputs present at that edge.
REQ-022 rst asserted mid-stream discards the pending result; no other state exists.

Verification
REQ-023 Reset: assert rst with arbitrary inputs -> all index = 32 without a clock edge.
REQ-024 Basic: inum=3, ilen {4,6,3}, psum {4,10,13}, ipos {0,5,11} -> after one edge index[0..3]=0..3, [4..9]=5..10, [10..12]=11..13, [13..31]=32.
REQ-025 Zero-length item: inum=3, ilen {2,0,3}, psum {2,2,5}, ipos {4,9,20} -> index[0..1]=4,5; [2..4]=20,21,22; [5..31]=32.
REQ-026 Full vector: inum=3, ilen {15,15,2}, psum {15,30,0}, ipos {0,0,0} -> index[0..14]=0..14, [15..29]=0..14, [30..31]=0,1; inum=0 with the same data -> all 32.
REQ-027 Source wrap: inum=1, ilen {4}, psum {4}, ipos {30} -> index[0..3]=30,31,0,1, rest 32.
REQ-028 Pipeline/reset: change inputs every cycle -> each result appears exactly one edge later; assert rst between edges -> index = 32 at once, and the next post-reset edge loads fresh inputs.
